// File: rtl/ysyx_22041752_rf_wport_arb_pkg.sv
// ============================================================================
// Module  : ysyx_22041752_rf_wport_arb_pkg
// Brief   : Shared widths, winner encoding and bus-width helper for the
//           register-file write-port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ysyx_22041752_rf_wport_arb_pkg;

    localparam int RF_ADDR_WD_DEF   = 5;
    localparam int RF_DATA_WD_DEF   = 64;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_WS   = 2'd1,
        WIN_MDU  = 2'd2
    } win_src_e;

    // Forward bus is packed as {we, wdata, waddr}.
    function automatic int fwd_bus_wd(input int addr_wd, input int data_wd);
        return 1 + data_wd + addr_wd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22041752_rf_wport_arb_if.sv
// ============================================================================
// Module  : ysyx_22041752_rf_wport_arb_if
// Brief   : Write-back, MDU, ID-hazard and register-file write signals
//           gathered around the write-port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ysyx_22041752_rf_wport_arb_if
    import ysyx_22041752_rf_wport_arb_pkg::*;
#(
    parameter int RF_ADDR_WD = RF_ADDR_WD_DEF,
    parameter int RF_DATA_WD = RF_DATA_WD_DEF
);
    localparam int RF_FWD_BUS_WD = fwd_bus_wd(RF_ADDR_WD, RF_DATA_WD);

    logic                     ws_we;
    logic [RF_ADDR_WD-1:0]    ws_waddr;
    logic [RF_DATA_WD-1:0]    ws_wdata;
    logic                     ws_hold;

    logic                     mdu_issue_valid;
    logic [RF_ADDR_WD-1:0]    mdu_issue_rd;
    logic                     mdu_busy;
    logic                     mdu_wb_valid;
    logic [RF_ADDR_WD-1:0]    mdu_wb_rd;
    logic [RF_DATA_WD-1:0]    mdu_wb_data;
    logic                     mdu_wb_ready;

    logic [RF_ADDR_WD-1:0]    id_rs1;
    logic [RF_ADDR_WD-1:0]    id_rs2;
    logic [RF_ADDR_WD-1:0]    id_rd;
    logic                     id_hazard;

    logic                     rf_we;
    logic [RF_ADDR_WD-1:0]    rf_waddr;
    logic [RF_DATA_WD-1:0]    rf_wdata;
    logic [RF_FWD_BUS_WD-1:0] fwd_bus;

    modport master (
        output ws_we, ws_waddr, ws_wdata,
        output mdu_issue_valid, mdu_issue_rd,
        output mdu_wb_valid, mdu_wb_rd, mdu_wb_data,
        output id_rs1, id_rs2, id_rd,
        input  ws_hold, mdu_busy, mdu_wb_ready, id_hazard,
        input  rf_we, rf_waddr, rf_wdata, fwd_bus
    );

    modport slave (
        input  ws_we, ws_waddr, ws_wdata,
        input  mdu_issue_valid, mdu_issue_rd,
        input  mdu_wb_valid, mdu_wb_rd, mdu_wb_data,
        input  id_rs1, id_rs2, id_rd,
        output ws_hold, mdu_busy, mdu_wb_ready, id_hazard,
        output rf_we, rf_waddr, rf_wdata, fwd_bus
    );

endinterface

`default_nettype wire

// File: rtl/ysyx_22041752_rf_wport_arb.sv
// ============================================================================
// Module  : ysyx_22041752_rf_wport_arb
// Brief   : Arbitrates the single RF write port between write-back and the MDU,
//           with starvation bound and one-entry MDU destination scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ysyx_22041752_rf_wport_arb
    import ysyx_22041752_rf_wport_arb_pkg::*;
#(
    parameter int RF_ADDR_WD   = RF_ADDR_WD_DEF,
    parameter int RF_DATA_WD   = RF_DATA_WD_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  wire                        clk,
    input  wire                        reset,
    ysyx_22041752_rf_wport_arb_if.slave bus
);

    localparam logic [3:0]            C_STARVE_MAX = 4'(STARVE_LIMIT - 1);
    localparam logic [RF_ADDR_WD-1:0] C_X0         = '0;

    logic                  pend_valid_q, pend_valid_d;
    logic [RF_ADDR_WD-1:0] pend_rd_q,    pend_rd_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;

    logic                  w_conflict;
    logic                  w_force;
    logic                  w_mdu_ready;
    win_src_e              w_win;
    logic [RF_ADDR_WD-1:0] w_waddr;
    logic [RF_DATA_WD-1:0] w_wdata;
    logic                  w_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_rd_q    <= '0;
            starve_cnt_q <= 4'd0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_rd_q    <= pend_rd_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        w_conflict  = bus.ws_we && bus.mdu_wb_valid;
        w_force     = w_conflict && (starve_cnt_q == C_STARVE_MAX);
        w_mdu_ready = bus.mdu_wb_valid && (!bus.ws_we || w_force);

        w_win   = WIN_NONE;
        w_waddr = '0;
        w_wdata = '0;
        if (bus.ws_we && !w_force) begin
            w_win   = WIN_WS;
            w_waddr = bus.ws_waddr;
            w_wdata = bus.ws_wdata;
        end else if (bus.mdu_wb_valid) begin
            w_win   = WIN_MDU;
            w_waddr = bus.mdu_wb_rd;
            w_wdata = bus.mdu_wb_data;
        end
        // x0 writes still complete the handshake; only the RF enable is dropped.
        w_we = (w_win != WIN_NONE) && (w_waddr != C_X0);
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (w_mdu_ready) begin
            starve_cnt_d = 4'd0;
        end else if (w_conflict) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        pend_valid_d = pend_valid_q;
        pend_rd_d    = pend_rd_q;
        if (bus.mdu_wb_valid && w_mdu_ready) begin
            pend_valid_d = 1'b0;
        end
        if (bus.mdu_issue_valid && (bus.mdu_issue_rd != C_X0)) begin
            pend_valid_d = 1'b1;
            pend_rd_d    = bus.mdu_issue_rd;
        end
    end

    assign bus.ws_hold      = w_force;
    assign bus.mdu_wb_ready = w_mdu_ready;
    assign bus.mdu_busy     = pend_valid_q;
    assign bus.id_hazard    = pend_valid_q && ((bus.id_rs1 == pend_rd_q) ||
                                               (bus.id_rs2 == pend_rd_q) ||
                                               (bus.id_rd  == pend_rd_q));
    assign bus.rf_we        = w_we;
    assign bus.rf_waddr     = w_waddr;
    assign bus.rf_wdata     = w_wdata;
    assign bus.fwd_bus      = {w_we, w_wdata, w_waddr};

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041752_rf_wport_arb.sv
// ============================================================================
// Module  : tb_ysyx_22041752_rf_wport_arb
// Brief   : Directed self-checking bench for the RF write-port arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22041752_rf_wport_arb;

    localparam int AW = 5;
    localparam int DW = 64;

    logic clk;
    logic reset;

    ysyx_22041752_rf_wport_arb_if #(.RF_ADDR_WD(AW), .RF_DATA_WD(DW)) u_if ();

    ysyx_22041752_rf_wport_arb #(
        .RF_ADDR_WD  (AW),
        .RF_DATA_WD  (DW),
        .STARVE_LIMIT(4)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Stimulus-side scoreboard used only for protocol assertions.
    logic          m_pend;
    logic [AW-1:0] m_rd;
    always @(posedge clk) begin
        if (reset) begin
            m_pend <= 1'b0;
        end else begin
            if (u_if.mdu_issue_valid)
                assert (!m_pend) else $error("illegal MDU issue while pending");
            if (u_if.mdu_wb_valid && u_if.mdu_wb_ready && m_pend) begin
                assert (u_if.mdu_wb_rd == m_rd) else $error("MDU wb rd differs from pending rd");
                m_pend <= 1'b0;
            end
            if (u_if.mdu_issue_valid && u_if.mdu_issue_rd != '0) begin
                m_pend <= 1'b1;
                m_rd   <= u_if.mdu_issue_rd;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.ws_we = 0; u_if.ws_waddr = '0; u_if.ws_wdata = '0;
        u_if.mdu_issue_valid = 0; u_if.mdu_issue_rd = '0;
        u_if.mdu_wb_valid = 0; u_if.mdu_wb_rd = '0; u_if.mdu_wb_data = '0;
        u_if.id_rs1 = '0; u_if.id_rs2 = '0; u_if.id_rd = '0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        u_if.mdu_issue_valid = 1; u_if.mdu_issue_rd = rd;
        step();
        u_if.mdu_issue_valid = 0; u_if.mdu_issue_rd = '0;
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        #1;
        chk("rst_rf_we",     u_if.rf_we, 0);
        chk("rst_fwd_bus",   u_if.fwd_bus, 0);
        chk("rst_ws_hold",   u_if.ws_hold, 0);
        chk("rst_mdu_busy",  u_if.mdu_busy, 0);
        chk("rst_id_hazard", u_if.id_hazard, 0);
        chk("rst_wb_ready",  u_if.mdu_wb_ready, 0);

        // Write-back only
        u_if.ws_we = 1; u_if.ws_waddr = 5; u_if.ws_wdata = 64'h11;
        #1;
        chk("wb_rf_we",    u_if.rf_we, 1);
        chk("wb_rf_waddr", u_if.rf_waddr, 5);
        chk("wb_rf_wdata", u_if.rf_wdata, 64'h11);
        chk("wb_fwd_bus",  u_if.fwd_bus, {1'b1, 64'h11, 5'd5});
        chk("wb_ws_hold",  u_if.ws_hold, 0);
        step();
        idle_inputs();

        // MDU only
        issue(7);
        u_if.id_rs1 = 7;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("mdu_busy_wait",   u_if.mdu_busy, 1);
            chk("mdu_hazard_wait", u_if.id_hazard, 1);
            if (c < 2) step();
        end
        u_if.mdu_wb_valid = 1; u_if.mdu_wb_rd = 7; u_if.mdu_wb_data = 64'hAB;
        #1;
        chk("mdu_wb_ready",  u_if.mdu_wb_ready, 1);
        chk("mdu_rf_we",     u_if.rf_we, 1);
        chk("mdu_rf_waddr",  u_if.rf_waddr, 7);
        chk("mdu_rf_wdata",  u_if.rf_wdata, 64'hAB);
        chk("mdu_hazard_hs", u_if.id_hazard, 1);
        step();
        idle_inputs();
        u_if.id_rs1 = 7;
        #1;
        chk("mdu_busy_after",   u_if.mdu_busy, 0);
        chk("mdu_hazard_after", u_if.id_hazard, 0);
        idle_inputs();

        // Starvation with limit 4
        issue(12);
        u_if.ws_we = 1; u_if.ws_waddr = 3; u_if.ws_wdata = 64'h33;
        u_if.mdu_wb_valid = 1; u_if.mdu_wb_rd = 12; u_if.mdu_wb_data = 64'hCC;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("starve_hold_lose",  u_if.ws_hold, 0);
            chk("starve_ready_lose", u_if.mdu_wb_ready, 0);
            chk("starve_waddr_lose", u_if.rf_waddr, 3);
            step();
        end
        chk("starve_force_hold",  u_if.ws_hold, 1);
        chk("starve_force_ready", u_if.mdu_wb_ready, 1);
        chk("starve_force_waddr", u_if.rf_waddr, 12);
        chk("starve_force_wdata", u_if.rf_wdata, 64'hCC);
        step();
        u_if.mdu_wb_valid = 0; u_if.mdu_wb_rd = '0; u_if.mdu_wb_data = '0;
        #1;
        chk("starve_after_hold",  u_if.ws_hold, 0);
        chk("starve_after_waddr", u_if.rf_waddr, 3);
        chk("starve_after_wdata", u_if.rf_wdata, 64'h33);
        chk("starve_after_busy",  u_if.mdu_busy, 0);
        step();
        idle_inputs();

        // x0 writes
        u_if.ws_we = 1; u_if.ws_waddr = 0; u_if.ws_wdata = 64'h55;
        #1;
        chk("x0_wb_rf_we", u_if.rf_we, 0);
        chk("x0_wb_hold",  u_if.ws_hold, 0);
        step();
        idle_inputs();
        issue(0);
        chk("x0_issue_busy", u_if.mdu_busy, 0);
        u_if.mdu_wb_valid = 1; u_if.mdu_wb_rd = 0; u_if.mdu_wb_data = 64'h77;
        #1;
        chk("x0_mdu_ready", u_if.mdu_wb_ready, 1);
        chk("x0_mdu_rf_we", u_if.rf_we, 0);
        step();
        idle_inputs();

        // WAW stall
        issue(9);
        u_if.id_rs1 = 1; u_if.id_rs2 = 2; u_if.id_rd = 9;
        #1;
        chk("waw_hazard", u_if.id_hazard, 1);
        u_if.id_rd = 10;
        #1;
        chk("waw_no_hazard", u_if.id_hazard, 0);
        u_if.mdu_wb_valid = 1; u_if.mdu_wb_rd = 9; u_if.mdu_wb_data = 64'h99;
        step();
        idle_inputs();

        // Reset mid-operation: two lost conflicts first
        issue(3);
        u_if.ws_we = 1; u_if.ws_waddr = 4; u_if.ws_wdata = 64'h44;
        u_if.mdu_wb_valid = 1; u_if.mdu_wb_rd = 3; u_if.mdu_wb_data = 64'h3C;
        step(); step();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
        u_if.id_rs1 = 3;
        #1;
        chk("rstmid_busy",   u_if.mdu_busy, 0);
        chk("rstmid_hazard", u_if.id_hazard, 0);
        idle_inputs();
        issue(3);
        u_if.ws_we = 1; u_if.ws_waddr = 4; u_if.ws_wdata = 64'h44;
        u_if.mdu_wb_valid = 1; u_if.mdu_wb_rd = 3; u_if.mdu_wb_data = 64'h3C;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("rstmid_hold_lose", u_if.ws_hold, 0);
            step();
        end
        chk("rstmid_force_hold", u_if.ws_hold, 1);
        step();
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
